seq_match_sched: RTL and testbench
==================================

Name: seq_match_sched

Overview:
- Shares one serial pattern-match engine between NCH independent bit-serial input channels.
- Each cycle, a round-robin arbiter grants at most one requesting channel. The engine updates that channel's saved context (history shift register plus fill count) and produces a registered Moore-style match indication.
- The engine generalises the team's fixed-pattern sequence detectors: the pattern is programmable and overlapping matches are detected.
- Sits between the serial front-end channels and the event/statistics logic.

Parameters:
- NCH, 4, number of input channels (2..8). Channel ID width is CW = clog2(NCH).
- PMAX, 8, maximum pattern length in bits. This is also the context shift-register width.
- CNTW, 8, width of the per-channel saturating match counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- cfg_wr  in  1  load pattern/length; clears all contexts and counters.
- cfg_pattern  in  PMAX  pattern. Bit [len-1] is the oldest (first-received) bit; bit 0 is the newest.
- cfg_len  in  4  pattern length in bits.
- req_valid  in  NCH  per-channel bit available.
- req_bit  in  NCH  per-channel serial data bit.
- req_ready  out  NCH  one-hot grant (or all zero). A bit is accepted when req_valid[i] & req_ready[i].
- match_valid  out  1  registered pulse: the last accepted bit completed a match.
- match_ch  out  CW  channel of the current match_valid pulse.
- cnt_sel  in  CW  counter read select.
- cnt_data  out  CNTW  match count of channel cnt_sel (combinational mux).

Behaviour:
- Reset (rst=0, async) sets:
  - all contexts to 0: hist = 0, fill = 0;
  - all counters to 0;
  - pattern to 0 and length to 0, so matching is disabled;
  - rr pointer to NCH-1, so channel 0 wins first;
  - match_valid = 0, match_ch = 0.
- Reset mid-stream discards all partial history. Outputs take their reset values immediately.
- Arbitration (combinational from req_valid, registered pointer):
  - Search starts at pointer+1, wrapping modulo NCH. The first valid channel is granted.
  - No valid request: req_ready = 0 and the pointer holds.
  - On an accept, the pointer becomes the granted index.
  - Exactly one accept per cycle, maximum.
  - A channel may hold req_valid across cycles. Its bit is not consumed until it is granted.
- Context update on accept for channel g:
  - hist_g <= {hist_g[PMAX-2:0], req_bit[g]};
  - fill_g <= min(fill_g+1, PMAX);
  - all other channels' contexts are unchanged.
- Effective length L:
  - cfg_len = 0 → L = 0: matching disabled, counters never increment.
  - cfg_len > PMAX → L = PMAX (clamped at config load).
- Match condition, evaluated on the post-update context:
  - L != 0, fill_g >= L, and hist_g[L-1:0] == pattern[L-1:0].
  - Overlap is allowed: the context is not cleared on a match.
- Output timing (Moore, latency 1):
  - An accept in cycle t gives match_valid=1 and match_ch=g in cycle t+1 if the condition held. Otherwise match_valid=0.
  - match_valid is high for one cycle per matching accept.
  - Back-to-back matches on different channels give consecutive pulses.
- Counters:
  - On a match, counter_g increments, saturating at 2^CNTW-1 (no wrap).
  - cnt_data reflects the update from cycle t+1 onward.
- cfg_wr has priority over everything else:
  - In the cfg_wr cycle, req_ready = 0 and no bit is accepted.
  - Pattern and length load. All hist, fill and counters clear.
  - match_valid = 0 in the following cycle.
  - The rr pointer is not changed.
- The only state machine is per-channel fill (0 → 1 → … → PMAX, saturating) plus the rr pointer. There is no multi-cycle engine FSM: throughput is 1 bit per cycle aggregate.

Decomposition:
- Package seq_match_pkg holds:
  - NCH, PMAX, CNTW defaults and the CW derivation;
  - the context struct {hist[PMAX], fill[4]};
  - the length clamp function.
- One sub-module, rr_arbiter (parameter N): inputs req, advance; outputs one-hot grant and index.
- Context array, match compare and counters stay in seq_match_sched.

Test Plan:
- Single channel, pattern 3'b101, len 3, ch0 stream 1,0,1,0,1 on consecutive cycles → match_valid pulses one cycle after the 3rd and 5th bits, match_ch=0; cnt_data(ch0)=2.
- All four req_valid held high, each channel fed 1,0,1 (pattern 101) → grant order 0,1,2,3,0,1,2,3,0,1,2,3; match pulses for ch0..ch3 in 4 consecutive cycles starting one cycle after the 9th accept.
- cfg_len=0 with ch0 stream all 1s for 20 bits → match_valid never asserts; counter stays 0. cfg_len=12 → clamped to 8; pattern 8'hFF matches from the 8th '1' onward, once per bit.
- Interleaved streams: ch1 sends 1,0 then ch2 sends 1,1, then ch1 sends 1 → ch1 match after its 3rd bit only; ch2 history does not disturb ch1.
- cfg_wr asserted while ch0 holds valid, after 2 of 3 pattern bits → ready low that cycle; ch0 needs 3 new bits before a match; counters read 0 after cfg_wr.
- Async reset pulse mid-stream and counter saturation: 300 matches with pattern 1'b1, len 1 → cnt_data=255. Reset low → cnt_data=0, match_valid=0 immediately; first grant after release goes to ch0.

Source files
------------

// File: rtl/seq_match_pkg.sv
// Shared types and constants for the multi-channel serial pattern matcher.
// Context layout, default sizing and the pattern-length clamp live here.
package seq_match_pkg;

    localparam int NCH  = 4;
    localparam int PMAX = 8;
    localparam int CNTW = 8;
    localparam int CW   = $clog2(NCH);

    typedef struct packed {
        logic [PMAX-1:0] hist;
        logic [3:0]      fill;
    } ctx_t;

    function automatic logic [3:0] clamp_len(input logic [3:0] len);
        if (int'(len) > PMAX) return 4'(PMAX);
        return len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from pointer+1, wrapping.
// The pointer moves to the granted index only when the grant is used.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            logic [IW-1:0] c;
            c = IW'((int'(ptr_q) + k) % N);
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = c;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= IW'(N - 1);
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/seq_match_sched.sv
// Time-shared programmable pattern matcher over NCH bit-serial channels.
// One granted bit per cycle updates that channel's context; match is registered.
module seq_match_sched
    import seq_match_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_wr,
    input  logic [PMAX-1:0] cfg_pattern,
    input  logic [3:0]      cfg_len,
    input  logic [NCH-1:0]  req_valid,
    input  logic [NCH-1:0]  req_bit,
    output logic [NCH-1:0]  req_ready,
    output logic            match_valid,
    output logic [CW-1:0]   match_ch,
    input  logic [CW-1:0]   cnt_sel,
    output logic [CNTW-1:0] cnt_data
);

    ctx_t            ctx_q [NCH];
    ctx_t            ctx_d [NCH];
    logic [CNTW-1:0] cnt_q [NCH];
    logic [CNTW-1:0] cnt_d [NCH];
    logic [PMAX-1:0] pat_q, pat_d;
    logic [3:0]      len_q, len_d;
    logic            mv_q, mv_d;
    logic [CW-1:0]   mch_q, mch_d;

    logic [NCH-1:0]  arb_req;
    logic [CW-1:0]   gidx;
    logic            accept;
    ctx_t            nctx;
    logic [PMAX-1:0] mask;
    logic            hit;

    // Config cycles block arbitration so no bit is consumed
    assign arb_req = cfg_wr ? '0 : req_valid;
    assign accept  = |req_ready;

    rr_arbiter #(.N(NCH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (accept),
        .grant   (req_ready),
        .idx     (gidx)
    );

    always_comb begin
        for (int i = 0; i < PMAX; i++) mask[i] = (i < int'(len_q));
        nctx.hist = {ctx_q[gidx].hist[PMAX-2:0], req_bit[gidx]};
        nctx.fill = (ctx_q[gidx].fill == 4'(PMAX)) ? 4'(PMAX)
                                                   : ctx_q[gidx].fill + 4'd1;
        hit = (len_q != 4'd0) && (nctx.fill >= len_q) &&
              (((nctx.hist ^ pat_q) & mask) == '0);
    end

    always_comb begin
        ctx_d = ctx_q;
        cnt_d = cnt_q;
        pat_d = pat_q;
        len_d = len_q;
        mv_d  = 1'b0;
        mch_d = mch_q;
        if (cfg_wr) begin
            pat_d = cfg_pattern;
            len_d = clamp_len(cfg_len);
            for (int c = 0; c < NCH; c++) begin
                ctx_d[c] = '0;
                cnt_d[c] = '0;
            end
        end else if (accept) begin
            ctx_d[gidx] = nctx;
            if (hit) begin
                mv_d  = 1'b1;
                mch_d = gidx;
                if (cnt_q[gidx] != '1) cnt_d[gidx] = cnt_q[gidx] + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NCH; c++) begin
                ctx_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            pat_q <= '0;
            len_q <= '0;
            mv_q  <= 1'b0;
            mch_q <= '0;
        end else begin
            ctx_q <= ctx_d;
            cnt_q <= cnt_d;
            pat_q <= pat_d;
            len_q <= len_d;
            mv_q  <= mv_d;
            mch_q <= mch_d;
        end
    end

    assign match_valid = mv_q;
    assign match_ch    = mch_q;
    assign cnt_data    = cnt_q[cnt_sel];

endmodule

// File: tb/tb_seq_match_sched.sv
// Directed and random bench for seq_match_sched against a queue-based model.
// Each channel's history is a plain list of received bits.
module tb_seq_match_sched;
    import seq_match_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cfg_wr = 1'b0;
    logic [PMAX-1:0] cfg_pattern = '0;
    logic [3:0]      cfg_len = '0;
    logic [NCH-1:0]  req_valid = '0;
    logic [NCH-1:0]  req_bit = '0;
    logic [NCH-1:0]  req_ready;
    logic            match_valid;
    logic [CW-1:0]   match_ch;
    logic [CW-1:0]   cnt_sel = '0;
    logic [CNTW-1:0] cnt_data;

    seq_match_sched dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr      (cfg_wr),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .req_valid   (req_valid),
        .req_bit     (req_bit),
        .req_ready   (req_ready),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .cnt_sel     (cnt_sel),
        .cnt_data    (cnt_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit sq [NCH][$];
    bit hq [NCH][$];
    int mcnt [NCH];
    int mptr;
    int mlen;
    logic [PMAX-1:0] mpat;
    int last_g;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            hq[c].delete();
            mcnt[c] = 0;
        end
        mptr = NCH - 1;
        mlen = 0;
        mpat = '0;
    endtask

    task automatic drive_q();
        for (int c = 0; c < NCH; c++) begin
            req_valid[c] = (sq[c].size() > 0);
            req_bit[c]   = (sq[c].size() > 0) ? sq[c][0] : 1'b0;
        end
    endtask

    task automatic step(input bit use_q);
        int g;
        bit hit;
        logic [NCH-1:0] exp_rdy;
        if (use_q) drive_q();
        #2;
        g = -1;
        if (!cfg_wr)
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (mptr + k) % NCH;
                if (g < 0 && req_valid[c]) g = c;
            end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        hit = 1'b0;
        last_g = g;
        if (cfg_wr) begin
            mpat = cfg_pattern;
            mlen = (int'(cfg_len) > PMAX) ? PMAX : int'(cfg_len);
            for (int c = 0; c < NCH; c++) begin
                hq[c].delete();
                mcnt[c] = 0;
            end
        end else if (g >= 0) begin
            hq[g].push_back(req_bit[g]);
            if (hq[g].size() > 16) void'(hq[g].pop_front());
            if (use_q) void'(sq[g].pop_front());
            mptr = g;
            if (mlen > 0 && hq[g].size() >= mlen) begin
                hit = 1'b1;
                for (int j = 0; j < mlen; j++)
                    if (hq[g][hq[g].size() - 1 - j] != mpat[j]) hit = 1'b0;
            end
            if (hit && mcnt[g] < 255) mcnt[g]++;
        end
        chk("match_valid", 32'(match_valid), 32'(hit));
        if (hit) chk("match_ch", 32'(match_ch), 32'(g));
        chk("cnt_data", 32'(cnt_data), 32'(mcnt[cnt_sel]));
        if (use_q) drive_q();
    endtask

    task automatic run(input int maxc);
        int n;
        bit busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < maxc) begin
            busy = 1'b0;
            for (int c = 0; c < NCH; c++) if (sq[c].size() > 0) busy = 1'b1;
            if (busy) begin
                step(1'b1);
                n++;
            end
        end
        busy = 1'b0;
        for (int c = 0; c < NCH; c++) if (sq[c].size() > 0) busy = 1'b1;
        chk("run_drained", 32'(busy), 32'd0);
    endtask

    task automatic cfg(input logic [PMAX-1:0] p, input logic [3:0] l);
        cfg_pattern = p;
        cfg_len = l;
        cfg_wr = 1'b1;
        step(1'b1);
        cfg_wr = 1'b0;
    endtask

    task automatic push(input int ch, input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) sq[ch].push_back(bits[i]);
    endtask

    task automatic read_cnt(input int ch, input int exp, input string tag);
        cnt_sel = CW'(ch);
        #1;
        chk(tag, 32'(cnt_data), 32'(exp));
    endtask

    initial begin
        model_reset();
        #1;
        chk("reset_mv", 32'(match_valid), 32'd0);
        chk("reset_ch", 32'(match_ch), 32'd0);
        chk("reset_cnt", 32'(cnt_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        cfg(8'b101, 4'd3);
        push(0, 32'b10101, 5);
        run(20);
        read_cnt(0, 2, "t1_cnt0");

        cfg(8'b101, 4'd3);
        for (int c = 0; c < NCH; c++) push(c, 32'b101, 3);
        run(30);
        for (int c = 0; c < NCH; c++) read_cnt(c, 1, "t2_cnt");

        cfg(8'hFF, 4'd0);
        push(0, 32'hFFFFF, 20);
        run(40);
        read_cnt(0, 0, "t3_len0_cnt");
        cfg(8'hFF, 4'd12);
        push(0, 32'hFFFFF, 20);
        run(40);
        read_cnt(0, 13, "t3_clamp_cnt");

        cfg(8'b101, 4'd3);
        push(1, 32'b10, 2);
        run(10);
        push(2, 32'b11, 2);
        run(10);
        push(1, 32'b1, 1);
        run(10);
        read_cnt(1, 1, "t4_cnt1");
        read_cnt(2, 0, "t4_cnt2");

        cfg(8'b101, 4'd3);
        push(0, 32'b10, 2);
        run(10);
        push(0, 32'b1, 1);
        cfg(8'b101, 4'd3);
        read_cnt(0, 0, "t5_cnt_after_cfg");
        run(10);
        push(0, 32'b01, 2);
        run(10);
        read_cnt(0, 1, "t5_cnt0");

        cfg(8'h01, 4'd1);
        for (int i = 0; i < 300; i++) sq[0].push_back(1'b1);
        run(400);
        read_cnt(0, 255, "sat_cnt0");

        push(0, 32'b1, 1);
        run(5);
        chk("pre_rst_mv", 32'(match_valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_mv", 32'(match_valid), 32'd0);
        chk("rst_cnt", 32'(cnt_data), 32'd0);
        chk("rst_ch", 32'(match_ch), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int c = 0; c < NCH; c++) push(c, 32'b1, 1);
        step(1'b1);
        chk("rst_first_grant", 32'(last_g), 32'd0);
        run(10);

        for (int i = 0; i < 400; i++) begin
            req_valid = NCH'($urandom);
            req_bit   = NCH'($urandom);
            cnt_sel   = CW'($urandom_range(0, NCH - 1));
            if ($urandom_range(0, 39) == 0) begin
                cfg_pattern = PMAX'($urandom);
                cfg_len = 4'($urandom_range(0, 15));
                cfg_wr = 1'b1;
            end
            step(1'b0);
            cfg_wr = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
